sort4_unpack: RTL and testbench
===============================

SORT4_UNPACK -- requirements
Module: sort4_unpack

Interface
REQ-001 Parameter SORT_LAT, default 4: cycles from a frame being presented at the 4-input sorter inputs to its sorted result appearing at the sorter outputs.
REQ-002 Parameter DEPTH, default 4: frame buffer depth, in whole 4-byte frames; a power of two, 2 or more.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  high in the cycle a frame is presented at the sorter inputs.
REQ-006 y0, y1, y2, y3  input  8 each  sorter outputs, ascending order (y0 is the minimum).
REQ-007 out_data  output  8  serialized byte.
REQ-008 out_valid  output  1  out_data holds a valid byte.
REQ-009 out_ready  input  1  downstream accepts the byte.
REQ-010 out_last  output  1  high with the 4th byte (y3) of each frame.
REQ-011 overflow  output  1  sticky; high once any frame has been dropped.
REQ-012 drop_cnt  output  8  number of dropped frames; saturates at 255.

Function
REQ-013 Valid tracking: in_valid SHALL pass through a SORT_LAT-stage shift register; the output of that register is cap_valid.
REQ-014 Capture: when cap_valid is high and the buffer is not full, y0..y3 SHALL be written as one frame entry on that rising edge.
REQ-015 Drop: when cap_valid is high and the buffer is full, the frame SHALL be discarded, overflow SHALL be set, and drop_cnt SHALL increment (saturating at 255).
REQ-016 Full/empty: write and read pointers SHALL be log2(DEPTH)+1 bits wide and wrap naturally at 2*DEPTH.
  - full: pointers equal in the low bits and differ in the MSB.
  - empty: pointers fully equal.
REQ-017 Simultaneous events: if cap_valid is high with the buffer full, and the final byte of the head frame is accepted in the same cycle, the frame SHALL be captured, not dropped.
REQ-018 Serializer: a 2-bit byte index sel SHALL select byte y[sel] of the head entry.
  - out_valid = buffer not empty.
  - out_last = out_valid and sel==3.
REQ-019 Handshake: a byte transfers when out_valid and out_ready are both high.
  - On transfer, sel increments.
  - On transfer at sel==3, sel returns to 0 and the read pointer advances.
REQ-020 Stability: while out_valid is high and out_ready is low, out_data, out_valid and out_last SHALL hold their values.
REQ-021 Latency: a frame captured at edge N SHALL present byte y0 with out_valid high from cycle N+1, combinationally from buffer state.
REQ-022 Throughput: one byte per cycle with out_ready held high; the sustained input rate is one frame per 4 cycles, above which frames drop.

Reset
REQ-023 On rst high at a rising edge, all of the following SHALL clear, and any partially sent frame is abandoned:
  - valid shift register
  - write and read pointers
  - sel
  - overflow
  - drop_cnt
REQ-024 During and immediately after reset: out_valid=0, out_last=0, out_data=0 (driven 0 while empty); buffer contents need not be cleared.
REQ-025 Frames in flight in the valid shift register at reset SHALL be lost, never captured.

Structure
REQ-026 A shared package SHALL hold SORT_LAT_DEF=4, BYTE_W=8 and FRAME_BYTES=4, so the sorter, the packer and this block share them.
REQ-027 The frame buffer SHALL be one sub-module, frame_fifo: 32-bit wide, DEPTH entries, with wr_en, rd_en, full and empty; the valid delay line and serializer stay in sort4_unpack.

Verification
REQ-028 Single frame: after reset, pulse in_valid; 4 cycles later y=(3,7,9,200), out_ready=1.
  - Required: out_data 3,7,9,200 on 4 consecutive cycles.
  - Required: out_last high on the 200 only.
REQ-029 Backpressure: out_ready=0 for 5 cycles mid-frame, after byte 7 was sent.
  - Required: 9 is held stable with out_valid=1.
  - Required: after release, 9 then 200 are sent, nothing lost or duplicated.
REQ-030 Overflow: out_ready=0, 5 frames at 1 per cycle.
  - Required: frames 1-4 buffered.
  - Required: frame 5 dropped; overflow=1 and drop_cnt=1.
  - Required: after release, 16 bytes emerge in order.
REQ-031 Full plus drain: buffer full, final byte of head accepted in the same cycle a new frame arrives.
  - Required: frame captured; drop_cnt unchanged.
  - Required: pointers wrap correctly over 3*DEPTH frames.
REQ-032 Reset mid-frame: assert rst after 2 bytes of a frame with 2 more frames in flight.
  - Required: next cycle out_valid=0, overflow=0, drop_cnt=0.
  - Required: no in-flight frames appear afterwards.
REQ-033 Saturation: force 300 drops.
  - Required: drop_cnt=255 and overflow=1.

Source files
------------

// File: rtl/sort4_unpack_pkg.sv
// Constants shared by the 4-input sorter, the frame packer and the sorted-frame unpacker.
package sort4_unpack_pkg;

  localparam int SORT_LAT_DEF = 4;
  localparam int BYTE_W       = 8;
  localparam int FRAME_BYTES  = 4;
  localparam int FRAME_W      = BYTE_W * FRAME_BYTES;

  typedef logic [BYTE_W-1:0]  byte_t;
  typedef logic [FRAME_W-1:0] frame_t;

  // Byte 0 (the minimum) lives in the least significant lane of a frame word.
  function automatic byte_t frame_byte(input frame_t f, input logic [1:0] idx);
    return f[idx*BYTE_W +: BYTE_W];
  endfunction

endpackage

// File: rtl/sort4_unpack_fifo.sv
// Frame buffer: DEPTH whole frames, first-word-fall-through read, extra pointer MSB for full/empty.
module frame_fifo
  import sort4_unpack_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   wr_en,
  input  frame_t wr_data,
  input  logic   rd_en,
  output frame_t rd_data,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  frame_t        mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  // NOTE: storage is deliberately left out of reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // NOTE: all state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

endmodule

// File: rtl/sort4_unpack.sv
// Captures sorted 4-byte frames behind the sorter latency, buffers them and serializes
// them byte by byte over a valid/ready stream, counting frames dropped on overflow.
module sort4_unpack
  import sort4_unpack_pkg::*;
#(
  parameter int SORT_LAT = SORT_LAT_DEF,
  parameter int DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  y0,
  input  logic [7:0]  y1,
  input  logic [7:0]  y2,
  input  logic [7:0]  y3,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        overflow,
  output logic [7:0]  drop_cnt
);

  logic [SORT_LAT-1:0] vld_sr;
  logic                cap_valid;
  logic [1:0]          sel;
  logic                xfer;
  logic                pop;
  logic                wr_en;
  logic                drop;
  logic                full;
  logic                empty;
  frame_t              head;

  // Valid delay line matching the sorter pipeline; reset flushes frames in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= in_valid;
      for (int i = 1; i < SORT_LAT; i++) vld_sr[i] <= vld_sr[i-1];
    end
  end

  assign cap_valid = vld_sr[SORT_LAT-1];
  assign xfer      = out_valid && out_ready;
  assign pop       = xfer && (sel == 2'd3);
  // A full buffer still accepts the frame when its head frame leaves in the same cycle.
  assign wr_en     = cap_valid && (!full || pop);
  assign drop      = cap_valid && full && !pop;

  frame_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data ({y3, y2, y1, y0}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sel      <= 2'd0;
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      if (xfer) sel <= sel + 2'd1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // Outputs come straight from buffer state, so they hold while the consumer stalls.
  assign out_valid = !empty;
  assign out_last  = !empty && (sel == 2'd3);
  assign out_data  = empty ? 8'd0 : frame_byte(head, sel);

endmodule

// File: tb/tb_sort4_unpack.sv
// Scoreboard bench for sort4_unpack: a sorter-latency model feeds y0..y3, expected bytes
// are queued when frames are sent and popped as the DUT hands bytes over.
module tb_sort4_unpack;
  import sort4_unpack_pkg::*;

  localparam int SL = 4;
  localparam int DP = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] y0, y1, y2, y3;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       overflow;
  logic [7:0] drop_cnt;

  sort4_unpack #(.SORT_LAT(SL), .DEPTH(DP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .y0        (y0),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          exp_drops;
  logic [8:0]  exp_q [$];
  logic [31:0] cur_frame;
  logic        pv [SL];
  logic [31:0] pd [SL];

  // One clock: score any handshake seen before the edge, then advance the sorter model.
  task automatic tick();
    logic        v;
    logic [31:0] f;
    logic [8:0]  e;
    v = in_valid;
    f = cur_frame;
    if (out_valid === 1'b1 && out_ready === 1'b1 && rst !== 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_byte got data=%0d last=%0b (none expected)", out_data, out_last);
      end else begin
        e = exp_q.pop_front();
        if ({out_last, out_data} !== e) begin
          failures++;
          $display("FAIL byte got data=%0d last=%0b exp data=%0d last=%0b",
                   out_data, out_last, e[7:0], e[8]);
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = SL-1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
    end
    pv[0] = v;
    pd[0] = f;
    if (pv[SL-1]) {y3, y2, y1, y0} = pd[SL-1];
    else          {y3, y2, y1, y0} = 32'hEEEE_EEEE;
  endtask

  task automatic push_frame(input logic [31:0] f);
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), f[i*8 +: 8]});
  endtask

  task automatic send(input logic [31:0] f, input bit expect_out);
    cur_frame = f;
    in_valid  = 1'b1;
    if (expect_out) push_frame(f);
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic drain(input int budget, output int n);
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain_timeout got %0d bytes left, exp 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic logic [31:0] mk_frame(input int k);
    return {8'(k*16+4), 8'(k*16+3), 8'(k*16+2), 8'(k*16+1)};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    checks++;
    if ({out_valid, out_last, out_data} !== 10'd0) begin
      failures++;
      $display("FAIL reset_during got v=%0b l=%0b d=%0d exp 0/0/0", out_valid, out_last, out_data);
    end
    rst = 1'b0;
    tick();
    exp_q.delete();
    exp_drops = 0;
    checks++;
    if ({out_valid, out_last, out_data, overflow, drop_cnt} !== 19'd0) begin
      failures++;
      $display("FAIL reset_after got v=%0b l=%0b d=%0d ovf=%0b drops=%0d exp all 0",
               out_valid, out_last, out_data, overflow, drop_cnt);
    end
  endtask

  task automatic test_single_frame();
    int n;
    out_ready = 1'b1;
    send({8'd200, 8'd9, 8'd7, 8'd3}, 1'b1);
    tick(); tick(); tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_early got out_valid=%0b exp 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'd3) begin
      failures++;
      $display("FAIL single_first got v=%0b d=%0d exp v=1 d=3", out_valid, out_data);
    end
    drain(20, n);
    checks++;
    if (n != 4 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_cycles got %0d cycles v=%0b exp 4 cycles v=0", n, out_valid);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int w;
    out_ready = 1'b1;
    send({8'd200, 8'd9, 8'd7, 8'd3}, 1'b1);
    w = 0;
    while (out_valid !== 1'b1 && w < 10) begin
      tick();
      w++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_wait got out_valid=%0b exp 1", out_valid);
    end
    tick(); tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'd9 || out_last !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got v=%0b d=%0d l=%0b exp v=1 d=9 l=0",
                 i, out_valid, out_data, out_last);
      end
      tick();
    end
    drain(20, n);
    checks++;
    if (n != 2) begin
      failures++;
      $display("FAIL bp_release got %0d cycles exp 2", n);
    end
  endtask

  task automatic test_overflow();
    int n;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) send(mk_frame(k + 1), (k < DP));
    exp_drops++;
    for (int i = 0; i <= SL; i++) tick();
    checks++;
    if (drop_cnt !== 8'(exp_drops) || overflow !== 1'b1 || out_data !== 8'd17) begin
      failures++;
      $display("FAIL ovf_state got drops=%0d ovf=%0b d=%0d exp drops=%0d ovf=1 d=17",
               drop_cnt, overflow, out_data, exp_drops);
    end
    drain(40, n);
    checks++;
    if (n != 16) begin
      failures++;
      $display("FAIL ovf_drain got %0d bytes exp 16", n);
    end
  endtask

  task automatic test_full_drain();
    int n;
    out_ready = 1'b0;
    for (int k = 0; k < DP; k++) send(mk_frame(k + 8), 1'b1);
    for (int i = 0; i <= SL; i++) tick();
    // New frame reaches capture on the edge that hands over the head frame's last byte.
    send(mk_frame(14), 1'b1);
    out_ready = 1'b1;
    tick(); tick(); tick(); tick();
    out_ready = 1'b0;
    tick();
    checks++;
    if (drop_cnt !== 8'(exp_drops) || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL full_drain got drops=%0d v=%0b exp drops=%0d v=1", drop_cnt, out_valid, exp_drops);
    end
    drain(60, n);
    out_ready = 1'b1;
    for (int k = 0; k < 3*DP; k++) begin
      send(mk_frame(k), 1'b1);
      tick(); tick(); tick();
    end
    drain(60, n);
    checks++;
    if (drop_cnt !== 8'(exp_drops) || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL wrap_stream got drops=%0d v=%0b exp drops=%0d v=0", drop_cnt, out_valid, exp_drops);
    end
  endtask

  task automatic test_reset_midframe();
    int seen;
    out_ready = 1'b1;
    send(mk_frame(3), 1'b1);
    tick(); tick(); tick();
    send(mk_frame(5), 1'b0);
    send(mk_frame(6), 1'b0);
    tick();
    checks++;
    if (exp_q.size() != 2) begin
      failures++;
      $display("FAIL mid_progress got %0d bytes pending exp 2", exp_q.size());
    end
    rst = 1'b1; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_drops = 0;
    checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 8'd0 || out_data !== 8'd0) begin
      failures++;
      $display("FAIL mid_reset got v=%0b ovf=%0b drops=%0d d=%0d exp 0/0/0/0",
               out_valid, overflow, drop_cnt, out_data);
    end
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid !== 1'b0) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL mid_inflight got %0d valid cycles exp 0", seen);
    end
  endtask

  task automatic test_saturation();
    out_ready = 1'b0;
    for (int k = 0; k < DP + 300; k++) send(mk_frame(k % 15), 1'b0);
    for (int i = 0; i <= SL; i++) tick();
    checks++;
    if (drop_cnt !== 8'd255 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL saturate got drops=%0d ovf=%0b exp 255/1", drop_cnt, overflow);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (drop_cnt !== 8'd0 || overflow !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL sat_reset got drops=%0d ovf=%0b v=%0b exp 0/0/0", drop_cnt, overflow, out_valid);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cur_frame = '0;
    {y3, y2, y1, y0} = '0;
    for (int i = 0; i < SL; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
    test_reset();
    test_single_frame();
    test_backpressure();
    test_overflow();
    test_full_drain();
    test_reset_midframe();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
